// File: rtl/hv_sync_generator.sv
// ----------------------------------------------------------------------------
// hv_sync_generator
//
// Free-running VGA raster timing generator. The default timing is
// 640x480@60 with a 25.175 MHz pixel clock and one pixel per clk. It
// produces the beam position and the sync pulses that the pixel renderer
// keys off.
//
// Ports:
//   clk        in   1   pixel clock, all state updates on the rising edge
//   reset      in   1   synchronous, active-high reset
//   hsync      out  1   horizontal sync, registered (active-low by default)
//   vsync      out  1   vertical sync, registered (active-low by default)
//   display_on out  1   1 while the beam is inside the visible area
//   hpos       out 10   current column, 0..H_MAX
//   vpos       out 10   current line,   0..V_MAX
//
// Configuration:
//   HVSYNC_POS_SYNC_EN  when defined, hsync/vsync are active-high and reset
//                       to 0. When undefined, they are active-low and reset
//                       to 1. Timing is identical in both modes.
// ----------------------------------------------------------------------------
module hv_sync_generator #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_BOTTOM  = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_TOP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos
);

    // Derived 10-bit timing points. All comparisons below are unsigned 10-bit.
    localparam logic [9:0] H_VIS        = 10'(H_DISPLAY);
    localparam logic [9:0] H_MAX        = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] H_SYNC_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_VIS        = 10'(V_DISPLAY);
    localparam logic [9:0] V_MAX        = 10'(V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1);
    localparam logic [9:0] V_SYNC_START = 10'(V_DISPLAY + V_BOTTOM);
    localparam logic [9:0] V_SYNC_END   = 10'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

    // Idle (deasserted) level of both sync outputs. The asserted level is its
    // complement.
`ifdef HVSYNC_POS_SYNC_EN
    localparam logic SYNC_IDLE = 1'b0;
`else
    localparam logic SYNC_IDLE = 1'b1;
`endif

    logic [9:0] hpos_q, hpos_d;
    logic [9:0] vpos_q, vpos_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       h_in_sync;
    logic       v_in_sync;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        hpos_d = hpos_q + 10'd1;
        vpos_d = vpos_q;

        // The line counter advances only on the last pixel of a line; the
        // frame wraps when that pixel is also on the last line.
        if (hpos_q == H_MAX) begin
            hpos_d = '0;
            if (vpos_q == V_MAX) begin
                vpos_d = '0;
            end else begin
                vpos_d = vpos_q + 10'd1;
            end
        end

        // The sync windows are decoded from the current position and then
        // registered, so both pulses lag the counters by exactly one clk.
        h_in_sync = (hpos_q >= H_SYNC_START) && (hpos_q <= H_SYNC_END);
        v_in_sync = (vpos_q >= V_SYNC_START) && (vpos_q <= V_SYNC_END);
        hsync_d   = h_in_sync ? ~SYNC_IDLE : SYNC_IDLE;
        vsync_d   = v_in_sync ? ~SYNC_IDLE : SYNC_IDLE;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            hpos_q  <= '0;
            vpos_q  <= '0;
            hsync_q <= SYNC_IDLE;
            vsync_q <= SYNC_IDLE;
        end else begin
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign hpos       = hpos_q;
    assign vpos       = vpos_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    // Combinational so the visible flag lines up with hpos/vpos with no lag.
    assign display_on = (hpos_q < H_VIS) && (vpos_q < V_VIS);

endmodule

// File: tb/tb_hv_sync_generator.sv
// ----------------------------------------------------------------------------
// tb_hv_sync_generator
//
// Two instances share one clock:
//   dut_m  uses the full 640x480@60 timing and checks line-level behaviour
//          and a reset asserted in mid-frame.
//   dut_s  keeps the full line timing but uses a 13-line frame
//          (6 visible, 2 front, 2 sync, 3 back). Frame wrap and vsync
//          behaviour can then be checked in a short run.
// A position model derived from the elapsed clk count since reset predicts
// every output on every cycle. Reset pulses are injected at random times.
// ----------------------------------------------------------------------------
module tb_hv_sync_generator;

    localparam int HT = 800;             // clks per line
    localparam int VT_M = 525;           // lines per frame, dut_m
    localparam int VT_S = 13;            // lines per frame, dut_s
    localparam int VDISP_M = 480;
    localparam int VDISP_S = 6;
    localparam int VSS_M = 490, VSE_M = 491;
    localparam int VSS_S = 8,   VSE_S = 9;

`ifdef HVSYNC_POS_SYNC_EN
    localparam logic ACT = 1'b1;
`else
    localparam logic ACT = 1'b0;
`endif
    localparam logic IDLE = ~ACT;

    logic       clk = 1'b0;
    logic       reset_m = 1'b1, reset_s = 1'b1;
    logic       hsync_m, vsync_m, disp_m, hsync_s, vsync_s, disp_s;
    logic [9:0] hpos_m, vpos_m, hpos_s, vpos_s;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: clks since the last reset edge, plus a valid flag.
    int t_m = 0, t_s = 0;
    bit valid_m = 0, valid_s = 0;

    always #5 clk = ~clk;

    hv_sync_generator dut_m (
        .clk(clk), .reset(reset_m), .hsync(hsync_m), .vsync(vsync_m),
        .display_on(disp_m), .hpos(hpos_m), .vpos(vpos_m)
    );

    hv_sync_generator #(
        .V_DISPLAY(6), .V_BOTTOM(2), .V_SYNC(2), .V_TOP(3)
    ) dut_s (
        .clk(clk), .reset(reset_s), .hsync(hsync_s), .vsync(vsync_s),
        .display_on(disp_s), .hpos(hpos_s), .vpos(vpos_s)
    );

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            if (n_bad < 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
            n_bad++;
        end
    endtask

    // Expected outputs for a frame of vt lines, t clks after reset.
    // The position is t mod frame length. Each sync reflects the window
    // the beam occupied one clk earlier.
    function automatic void model(input int t, input int vt, input int vdisp,
                                  input int vss, input int vse,
                                  output int h, output int v, output int d,
                                  output int hs, output int vs);
        int ph, pv;
        h = t % HT;
        v = (t / HT) % vt;
        d = (h < 640 && v < vdisp) ? 1 : 0;
        if (t == 0) begin
            hs = IDLE;
            vs = IDLE;
        end else begin
            ph = (t - 1) % HT;
            pv = ((t - 1) / HT) % vt;
            hs = (ph >= 656 && ph <= 751) ? ACT : IDLE;
            vs = (pv >= vss && pv <= vse) ? ACT : IDLE;
        end
    endfunction

    always @(posedge clk) begin
        if (reset_m) begin
            t_m <= 0; valid_m <= 1;
        end else if (valid_m) begin
            t_m <= t_m + 1;
        end
        if (reset_s) begin
            t_s <= 0; valid_s <= 1;
        end else if (valid_s) begin
            t_s <= t_s + 1;
        end
    end

    // Cycle-by-cycle compare, sampled on the falling edge.
    always @(negedge clk) begin
        int h, v, d, hs, vs;
        if (valid_m) begin
            model(t_m, VT_M, VDISP_M, VSS_M, VSE_M, h, v, d, hs, vs);
            check("m_hpos", int'(hpos_m), h);
            check("m_vpos", int'(vpos_m), v);
            check("m_display_on", int'(disp_m), d);
            check("m_hsync", int'(hsync_m), hs);
            check("m_vsync", int'(vsync_m), vs);
        end
        if (valid_s) begin
            model(t_s, VT_S, VDISP_S, VSS_S, VSE_S, h, v, d, hs, vs);
            check("s_hpos", int'(hpos_s), h);
            check("s_vpos", int'(vpos_s), v);
            check("s_display_on", int'(disp_s), d);
            check("s_hsync", int'(hsync_s), hs);
            check("s_vsync", int'(vsync_s), vs);
        end
    end

    initial begin
        int hs_first, hs_last, hs_cnt, dark_cnt;
        int vs_first_h, vs_first_v, vs_last_h, vs_last_v, vs_cnt;
        bit found;

        // Reset held for three edges.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hpos", int'(hpos_m), 0);
        check("rst_vpos", int'(vpos_m), 0);
        check("rst_hsync", int'(hsync_m), int'(IDLE));
        check("rst_vsync", int'(vsync_m), int'(IDLE));
        check("rst_display_on", int'(disp_m), 1);
        reset_m = 1'b0;
        reset_s = 1'b0;

        // Scan one full frame of dut_s. The first 800 clks also scan line 0
        // of dut_m.
        hs_first = -1; hs_last = -1; hs_cnt = 0; dark_cnt = 0;
        vs_first_h = -1; vs_first_v = -1; vs_last_h = -1; vs_last_v = -1; vs_cnt = 0;
        for (int i = 1; i <= 10400; i++) begin
            @(negedge clk);
            if (i <= 800) begin
                if (hsync_m == ACT) begin
                    if (hs_first < 0) hs_first = int'(hpos_m);
                    hs_last = int'(hpos_m);
                    hs_cnt++;
                end
                if (!disp_m) dark_cnt++;
            end
            if (i == 799) check("line_end_hpos", int'(hpos_m), 799);
            if (i == 800) begin
                check("wrap_hpos", int'(hpos_m), 0);
                check("wrap_vpos", int'(vpos_m), 1);
            end
            if (vsync_s == ACT) begin
                if (vs_first_h < 0) begin
                    vs_first_h = int'(hpos_s);
                    vs_first_v = int'(vpos_s);
                end
                vs_last_h = int'(hpos_s);
                vs_last_v = int'(vpos_s);
                vs_cnt++;
            end
        end
        check("hsync_first_hpos", hs_first, 657);
        check("hsync_last_hpos", hs_last, 752);
        check("hsync_low_count", hs_cnt, 96);
        check("dark_count_line0", dark_cnt, 160);
        check("vsync_first_hpos", vs_first_h, 1);
        check("vsync_first_vpos", vs_first_v, 8);
        check("vsync_last_hpos", vs_last_h, 0);
        check("vsync_last_vpos", vs_last_v, 10);
        check("vsync_low_count", vs_cnt, 1600);
        check("frame_wrap_hpos", int'(hpos_s), 0);
        check("frame_wrap_vpos", int'(vpos_s), 0);

        // Reset in mid-frame on dut_m at (300,20).
        found = 0;
        for (int i = 0; i < 20000 && !found; i++) begin
            @(negedge clk);
            if (hpos_m == 10'd300 && vpos_m == 10'd20) found = 1;
        end
        check("mid_reset_reached", int'(found), 1);
        reset_m = 1'b1;
        @(negedge clk);
        check("mid_reset_hpos", int'(hpos_m), 0);
        check("mid_reset_vpos", int'(vpos_m), 0);
        check("mid_reset_hsync", int'(hsync_m), int'(IDLE));
        check("mid_reset_vsync", int'(vsync_m), int'(IDLE));
        reset_m = 1'b0;
        @(negedge clk);
        check("resume_hpos", int'(hpos_m), 1);
        check("resume_vpos", int'(vpos_m), 0);

        // Random reset pulses on either instance. The compare process
        // follows them.
        for (int k = 0; k < 16; k++) begin
            repeat ($urandom_range(50, 2500)) @(negedge clk);
            if ($urandom_range(0, 1) == 0) reset_m = 1'b1;
            else reset_s = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            reset_m = 1'b0;
            reset_s = 1'b0;
        end
        repeat (1000) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
